// File: rtl/udp_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_pkg
// Description : Shared types, constants and byte-ordering helpers for the
//               UDP transmit framer.
//                 - udp_tx_state_e : framer state encoding
//                 - UDP_HDR_BYTES  : UDP header size in bytes
//                 - be32_to_bytes  : 32-bit word -> 4 bytes in wire order,
//                                    with wire byte 0 placed in bits [7:0]
//                 - udp_len        : UDP length field for n payload words
// Revision    : 1.0 - initial release
// ============================================================================
package udp_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } udp_tx_state_e;

    localparam int UDP_HDR_BYTES = 8;

    // Network order is big-endian, while the stream puts byte 0 in the
    // least significant lane, so the most significant byte lands in [7:0].
    function automatic logic [31:0] be32_to_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [15:0] udp_len(input int n);
        return 16'(UDP_HDR_BYTES + 4 * n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_framer
// Description : Packs N_WORDS 32-bit result words into one UDP datagram
//               (8-byte header, zero checksum, then payload) and emits it on
//               a 64-bit AXI-Stream master with tkeep/tlast.
// Ports       : clk, rstn (async, active low)
//               src_port/dst_port : UDP ports, sampled when a datagram starts
//               in_data/in_valid/in_ready : payload word handshake
//               m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready : output stream
//               dgram_cnt : completed datagrams, free-running wrap
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_framer
    import udp_tx_pkg::*;
#(
    parameter int N_WORDS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] dgram_cnt
);

    localparam int                  c_word_w   = $clog2(N_WORDS + 1);
    localparam logic [c_word_w-1:0] c_last_idx = c_word_w'(N_WORDS - 1);
    localparam logic [15:0]         c_udp_len  = udp_len(N_WORDS);

    udp_tx_state_e        r_state;
    udp_tx_state_e        w_state_next;
    logic [c_word_w-1:0]  r_word_cnt;
    logic                 r_half;
    logic [31:0]          r_lo;
    logic [63:0]          r_tdata;
    logic [7:0]           r_tkeep;
    logic                 r_tlast;
    logic                 r_tvalid;
    logic [31:0]          r_dgram_cnt;

    logic w_out_free;
    logic w_out_hs;
    logic w_last_word;
    logic w_emit;
    logic w_in_ready;
    logic w_load_hdr;
    logic w_accept;

    assign w_out_free  = !r_tvalid || m_tready;
    assign w_out_hs    = r_tvalid && m_tready;
    assign w_last_word = (r_word_cnt == c_last_idx);
    // A word produces an output beat when it completes a pair, or when it is
    // the unpaired final word of an odd-length datagram.
    assign w_emit      = r_half || w_last_word;
    assign w_accept    = (r_state == PAYLOAD) && in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_load_hdr   = 1'b0;
        case (r_state)
            IDLE: begin
                // The first word only triggers the header; it is consumed
                // later in PAYLOAD.
                if (in_valid && w_out_free) begin
                    w_load_hdr   = 1'b1;
                    w_state_next = HDR;
                end
            end
            HDR: begin
                if (w_out_hs) begin
                    w_state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Parking the first word of a pair in r_lo needs no output
                // slot, so it is accepted even while the stream is stalled.
                w_in_ready = w_emit ? w_out_free : 1'b1;
                if (in_valid && w_in_ready && w_last_word) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_hs) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: output register, pair buffer, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_word_cnt  <= '0;
            r_half      <= 1'b0;
            r_lo        <= 32'h0;
            r_tdata     <= 64'h0;
            r_tkeep     <= 8'h00;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_dgram_cnt <= 32'h0;
        end else begin
            if (w_out_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            if (w_load_hdr) begin
                // Wire bytes 0..7: src, dst, len (all big-endian), checksum 0.
                r_tdata    <= {be32_to_bytes({c_udp_len, 16'h0000}),
                               be32_to_bytes({src_port, dst_port})};
                r_tkeep    <= 8'hFF;
                r_tlast    <= 1'b0;
                r_tvalid   <= 1'b1;
                r_word_cnt <= '0;
                r_half     <= 1'b0;
            end

            if (w_accept) begin
                r_word_cnt <= r_word_cnt + c_word_w'(1);
                if (w_emit) begin
                    r_tdata  <= r_half ? {be32_to_bytes(in_data), be32_to_bytes(r_lo)}
                                       : {32'h0, be32_to_bytes(in_data)};
                    r_tkeep  <= r_half ? 8'hFF : 8'h0F;
                    r_tlast  <= w_last_word;
                    r_tvalid <= 1'b1;
                    r_half   <= 1'b0;
                end else begin
                    r_lo   <= in_data;
                    r_half <= 1'b1;
                end
            end

            if ((r_state == DRAIN) && w_out_hs) begin
                r_dgram_cnt <= r_dgram_cnt + 32'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign m_tdata   = r_tdata;
    assign m_tkeep   = r_tkeep;
    assign m_tlast   = r_tlast;
    assign m_tvalid  = r_tvalid;
    assign dgram_cnt = r_dgram_cnt;

endmodule
`default_nettype wire
